// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM states, reset PC and bubble encoding.
package pipeline_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and imem (slave).
interface instruction_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program-counter register: synchronous active-low reset, load-enabled.
module pc_register #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)    q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, requests imem, feeds IF/ID. Optional skid buffer via FETCH_SKID_EN.
//   state | meaning
//   FETCH | request outstanding at pc_q; instruction passes straight through on ack
//   HOLD  | stalled instruction parked in buf_q, no memory traffic (FETCH_SKID_EN only)
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pc_write,
  input  logic                             redirect,
  input  logic [31:0]                      redirect_target,
  instruction_fetch_unit_if.master         imem,
  output logic [31:0]                      instruction_out,
  output logic [31:0]                      pc_out,
  output logic                             if_valid,
  output logic                             flush_out
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_inc;
  logic        pc_load;
  logic        in_hold;
  logic [31:0] hold_instr;

  assign pc_inc = pc_q + PC_INC;

  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc_q)
  );

`ifdef FETCH_SKID_EN
  fetch_state_t state_q;
  logic [31:0]  buf_q;

  // A redirect always wins and drops whatever was fetched or parked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      buf_q   <= NOP_INSTR;
    end else if (redirect) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.ack && !pc_write) begin
            buf_q   <= imem.rdata;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (pc_write) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign in_hold    = (state_q == HOLD);
  assign hold_instr = buf_q;
`else
  // Without the skid buffer a stall simply re-requests pc_q every cycle.
  assign in_hold    = 1'b0;
  assign hold_instr = NOP_INSTR;
`endif

  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc_inc;
    if (redirect) begin
      pc_load = 1'b1;
      pc_d    = redirect_target;
    end else if (in_hold) begin
      pc_load = pc_write;
    end else begin
      pc_load = imem.ack & pc_write;
    end
  end

  // Outputs are forced quiet while reset is held, before pc_q has a defined value.
  always_comb begin
    imem.req        = 1'b0;
    if_valid        = 1'b0;
    instruction_out = NOP_INSTR;
    if (rst_n) begin
      if (in_hold) begin
        if_valid        = ~redirect;
        instruction_out = hold_instr;
      end else begin
        imem.req = 1'b1;
        if_valid = imem.ack & ~redirect;
        if (imem.ack) instruction_out = imem.rdata;
      end
    end
  end

  assign imem.addr = pc_q;
  assign pc_out    = rst_n ? pc_inc : (RESET_PC + PC_INC);
  assign flush_out = rst_n & redirect;

endmodule
